// File: rtl/mmio_timer_regs_if.sv
// Bus bundle between the core's data-port MMIO decode and the timer
// register block. The master drives the access strobe, byte enables,
// word index and store data. The slave returns the registered load
// data and the timer interrupt level.
interface mmio_timer_regs_if;
    logic        i_mmio_enable;
    logic [3:0]  i_we;
    logic [2:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_timer_irq;

    modport master (
        output i_mmio_enable, i_we, i_addr, i_wdata,
        input  o_rdata, o_timer_irq
    );

    modport slave (
        input  i_mmio_enable, i_we, i_addr, i_wdata,
        output o_rdata, o_timer_irq
    );
endinterface

// File: rtl/mmio_timer_regs.sv
// MMIO register responder: 64-bit prescaled mtime/mtimecmp timer,
// sticky pending flag (write-1-to-clear), scratch register and registered
// read data. A read of MTIME_LO snapshots the upper half into a shadow so
// that a following MTIME_HI read returns a coherent 64-bit value.
module mmio_timer_regs #(
    parameter int          PRESCALE_W     = 8,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic             clk,
    input  logic             reset,
    mmio_timer_regs_if.slave bus
);

    // CTRL keeps only EN, IE and the PRESC field; every other bit reads 0.
    localparam logic [31:0] PRESC_FIELD = ((32'd1 << PRESCALE_W) - 32'd1) << 8;
    localparam logic [31:0] CTRL_MASK   = PRESC_FIELD | 32'h0000_0003;

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_MTIME_LO = 3'd1;
    localparam logic [2:0] A_MTIME_HI = 3'd2;
    localparam logic [2:0] A_CMP_LO   = 3'd3;
    localparam logic [2:0] A_CMP_HI   = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;
    localparam logic [2:0] A_SCRATCH  = 3'd6;

    logic [31:0]           ctrl_q,      ctrl_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [63:0]           mtime_q,     mtime_d;
    logic [63:0]           mtimecmp_q,  mtimecmp_d;
    logic [31:0]           hi_shadow_q, hi_shadow_d;
    logic [31:0]           scratch_q,   scratch_d;
    logic                  pend_q,      pend_d;
    logic                  irq_q,       irq_d;
    logic [31:0]           rdata_q,     rdata_d;

    logic                  wr_en;
    logic                  rd_en;
    logic                  tick;
    logic                  cmp;
    logic                  w1c;
    logic [PRESCALE_W-1:0] presc;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    assign wr_en = bus.i_mmio_enable && (bus.i_we != 4'b0000);
    assign rd_en = bus.i_mmio_enable && (bus.i_we == 4'b0000);
    assign presc = ctrl_q[8 +: PRESCALE_W];
    assign tick  = ctrl_q[0] && (presc_cnt_q == presc);
    assign cmp   = (mtime_q >= mtimecmp_q);

    // Next-state logic: timer advance, bus writes (which win over the tick), pending flag and read mux.
    always_comb begin
        ctrl_d      = ctrl_q;
        presc_cnt_d = presc_cnt_q;
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        hi_shadow_d = hi_shadow_q;
        scratch_d   = scratch_q;
        rdata_d     = rdata_q;
        w1c         = 1'b0;

        if (ctrl_q[0]) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        end
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr_en) begin
            case (bus.i_addr)
                A_CTRL: begin
                    ctrl_d      = merge_bytes(ctrl_q, bus.i_wdata, bus.i_we) & CTRL_MASK;
                    presc_cnt_d = '0;
                end
                A_MTIME_LO: mtime_d = {mtime_q[63:32],
                                       merge_bytes(mtime_q[31:0], bus.i_wdata, bus.i_we)};
                A_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], bus.i_wdata, bus.i_we),
                                       mtime_q[31:0]};
                A_CMP_LO:   mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], bus.i_wdata, bus.i_we);
                A_CMP_HI:   mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.i_wdata, bus.i_we);
                A_STATUS:   w1c = bus.i_we[0] && bus.i_wdata[0];
                A_SCRATCH:  scratch_d = merge_bytes(scratch_q, bus.i_wdata, bus.i_we);
                default: ;
            endcase
        end

        // A compare hit in the same cycle as a clear keeps the flag set.
        pend_d = (pend_q && !w1c) || cmp;
        irq_d  = pend_q && ctrl_q[1];

        if (rd_en) begin
            case (bus.i_addr)
                A_CTRL:     rdata_d = ctrl_q;
                A_MTIME_LO: begin
                    rdata_d     = mtime_q[31:0];
                    hi_shadow_d = mtime_q[63:32];
                end
                A_MTIME_HI: rdata_d = hi_shadow_q;
                A_CMP_LO:   rdata_d = mtimecmp_q[31:0];
                A_CMP_HI:   rdata_d = mtimecmp_q[63:32];
                A_STATUS:   rdata_d = {31'd0, pend_q};
                A_SCRATCH:  rdata_d = scratch_q;
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    // State registers; reset clears everything immediately, aborting any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q      <= 32'd0;
            presc_cnt_q <= '0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= MTIMECMP_RESET;
            hi_shadow_q <= 32'd0;
            scratch_q   <= 32'd0;
            pend_q      <= 1'b0;
            irq_q       <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            presc_cnt_q <= presc_cnt_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            hi_shadow_q <= hi_shadow_d;
            scratch_q   <= scratch_d;
            pend_q      <= pend_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.o_rdata     = rdata_q;
    assign bus.o_timer_irq = irq_q;

endmodule

// File: tb/tb_mmio_timer_regs.sv
// Bench for mmio_timer_regs: a table of register accesses after reset,
// then hand-written sequences for prescaled counting, the atomic 64-bit
// read across a wrap, the interrupt flag and a write racing a tick.
// Expected read data is queued when a read is issued and compared when
// the registered data appears one cycle later.
module tb_mmio_timer_regs;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mmio_timer_regs_if bus_if ();

    mmio_timer_regs #(
        .PRESCALE_W    (8),
        .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [3:0]  we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One bus access per cycle: drive on the falling edge, settle after the rising edge.
    task automatic access(input logic [3:0] we, input logic [2:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp,
                          input string name);
        sb_t e;
        @(negedge clk);
        bus_if.i_mmio_enable = 1'b1;
        bus_if.i_we          = we;
        bus_if.i_addr        = addr;
        bus_if.i_wdata       = wdata;
        if (we == 4'b0000) begin
            e.exp  = exp;
            e.name = name;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (we == 4'b0000) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check(e.name, bus_if.o_rdata, e.exp);
            end
        end
    endtask

    task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
        access(4'b0000, addr, 32'd0, exp, name);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wdata);
        access(4'b1111, addr, wdata, 32'd0, "");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_if.i_mmio_enable = 1'b0;
            bus_if.i_we          = 4'($urandom);
            bus_if.i_addr        = 3'($urandom);
            bus_if.i_wdata       = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst                  = 1'b1;
        bus_if.i_mmio_enable = 1'b0;
        bus_if.i_we          = 4'b0000;
        bus_if.i_addr        = 3'd0;
        bus_if.i_wdata       = 32'd0;

        // Random bus traffic, including writes, while reset is held.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_if.i_mmio_enable = 1'b1;
            bus_if.i_we          = 4'($urandom);
            bus_if.i_addr        = 3'($urandom);
            bus_if.i_wdata       = $urandom;
            @(posedge clk);
            #1;
        end
        check("reset_rdata", bus_if.o_rdata, 32'd0);
        check("reset_irq", {31'd0, bus_if.o_timer_irq}, 32'd0);
        @(negedge clk);
        rst                  = 1'b0;
        bus_if.i_mmio_enable = 1'b0;
        idle(1);

        // Register map after reset, byte strobes and masked fields.
        vecs.push_back('{4'b0000, 3'd0, 32'd0,         32'h0000_0000, "rst_ctrl"});
        vecs.push_back('{4'b0000, 3'd1, 32'd0,         32'h0000_0000, "rst_mtime_lo"});
        vecs.push_back('{4'b0000, 3'd2, 32'd0,         32'h0000_0000, "rst_hi_shadow"});
        vecs.push_back('{4'b0000, 3'd3, 32'd0,         32'hFFFF_FFFF, "rst_cmp_lo"});
        vecs.push_back('{4'b0000, 3'd4, 32'd0,         32'hFFFF_FFFF, "rst_cmp_hi"});
        vecs.push_back('{4'b0000, 3'd5, 32'd0,         32'h0000_0000, "rst_status"});
        vecs.push_back('{4'b0000, 3'd6, 32'd0,         32'h0000_0000, "rst_scratch"});
        vecs.push_back('{4'b0000, 3'd7, 32'd0,         32'h0000_0000, "rst_reserved"});
        vecs.push_back('{4'b0101, 3'd6, 32'hDEAD_BEEF, 32'h0,         ""});
        vecs.push_back('{4'b0000, 3'd6, 32'd0,         32'h00AD_00EF, "scratch_be0101"});
        vecs.push_back('{4'b1010, 3'd6, 32'h1234_5678, 32'h0,         ""});
        vecs.push_back('{4'b0000, 3'd6, 32'd0,         32'h12AD_56EF, "scratch_be1010"});
        vecs.push_back('{4'b1111, 3'd0, 32'hFFFF_FFFC, 32'h0,         ""});
        vecs.push_back('{4'b0000, 3'd0, 32'd0,         32'h0000_FF00, "ctrl_mask"});
        vecs.push_back('{4'b1111, 3'd0, 32'h0000_0000, 32'h0,         ""});
        vecs.push_back('{4'b0000, 3'd0, 32'd0,         32'h0000_0000, "ctrl_clear"});
        vecs.push_back('{4'b1111, 3'd7, 32'hFFFF_FFFF, 32'h0,         ""});
        vecs.push_back('{4'b0000, 3'd7, 32'd0,         32'h0000_0000, "reserved_wr"});
        vecs.push_back('{4'b1111, 3'd5, 32'hFFFF_FFFE, 32'h0,         ""});
        vecs.push_back('{4'b0000, 3'd5, 32'd0,         32'h0000_0000, "status_ro_bits"});
        vecs.push_back('{4'b0000, 3'd6, 32'd0,         32'h12AD_56EF, "scratch_reread"});
        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);
        end

        // Read data holds while the strobe is low.
        idle(2);
        check("rdata_hold", bus_if.o_rdata, 32'h12AD_56EF);

        // PRESC=0: one increment per cycle after the enabling write.
        wr(3'd0, 32'h0000_0001);
        idle(10);
        rd(3'd1, 32'd10, "count_presc0");

        // PRESC=3: one increment every fourth cycle.
        wr(3'd0, 32'h0000_0000);
        wr(3'd1, 32'h0000_0000);
        wr(3'd2, 32'h0000_0000);
        wr(3'd0, 32'h0000_0301);
        idle(11);
        rd(3'd1, 32'd2, "count_presc3_a");
        rd(3'd1, 32'd3, "count_presc3_b");

        // LO read at the carry into the upper half; HI returns the snapshot.
        wr(3'd0, 32'h0000_0000);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd2, 32'h0000_0000);
        wr(3'd0, 32'h0000_0001);
        rd(3'd1, 32'hFFFF_FFFF, "wrap_lo");
        rd(3'd2, 32'h0000_0000, "wrap_hi_shadow");
        rd(3'd1, 32'h0000_0001, "post_wrap_lo");
        rd(3'd2, 32'h0000_0001, "post_wrap_hi");

        // Compare at 20, pending flag, irq one cycle behind, clear racing a hit.
        wr(3'd0, 32'h0000_0000);
        wr(3'd1, 32'h0000_0000);
        wr(3'd2, 32'h0000_0000);
        wr(3'd4, 32'h0000_0000);
        wr(3'd3, 32'd20);
        wr(3'd0, 32'h0000_0003);
        idle(20);
        rd(3'd5, 32'd0, "pend_before_hit");
        check("irq_before_hit", {31'd0, bus_if.o_timer_irq}, 32'd0);
        rd(3'd5, 32'd1, "pend_set");
        check("irq_rise", {31'd0, bus_if.o_timer_irq}, 32'd1);
        wr(3'd5, 32'h0000_0001);
        rd(3'd5, 32'd1, "pend_set_wins");
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd4, 32'hFFFF_FFFF);
        wr(3'd5, 32'h0000_0001);
        check("irq_lags_clear", {31'd0, bus_if.o_timer_irq}, 32'd1);
        rd(3'd5, 32'd0, "pend_cleared");
        check("irq_cleared", {31'd0, bus_if.o_timer_irq}, 32'd0);

        // HI write in a tick cycle: no increment, low half unchanged.
        wr(3'd0, 32'h0000_0000);
        wr(3'd1, 32'h0000_0100);
        wr(3'd0, 32'h0000_0001);
        wr(3'd2, 32'h0000_ABCD);
        rd(3'd1, 32'h0000_0100, "hi_write_lo_kept");
        rd(3'd2, 32'h0000_ABCD, "hi_write_value");
        rd(3'd7, 32'h0000_0000, "reserved_read");

        idle(1);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
